// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader: FSM states, the default
// frame start byte and the largest image the instruction memory can hold.
package loader_pkg;

    // Loader FSM states, in frame order followed by the two terminal states.
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_e;

    // Byte that opens every frame.
    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Instruction memory depth in 16-bit words (15-bit word address).
    localparam int unsigned MAX_WORDS = 32768;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);

    // True while a frame is being received (header, payload or checksum).
    function automatic logic isFrameState(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == CHECK);
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte stream in from the UART receiver and word write port out to the
// instruction memory, bundled so the loader and its neighbours share one bus.
interface rom_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;

    // The loader: consumes received bytes, drives the memory write port.
    modport master (
        input  rx_data,
        input  rx_valid,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );

    // The surroundings: byte source and instruction memory.
    modport slave (
        output rx_data,
        output rx_valid,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

endinterface

// File: rtl/rom_loader_idle_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// flags when the count reaches TIMEOUT_CYCLES. Saturates so it never wraps.
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over counting; counting stops once the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/rom_loader.sv
// Boot loader: receives a framed program image over the UART byte stream,
// writes it word by word into instruction memory and releases the CPU from
// reset only after a frame with a matching checksum has been fully loaded.
module rom_loader
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    rom_loader_if.master bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    state_e      state_q,    state_d;
    logic [15:0] len_q,      len_d;
    logic [7:0]  wordHi_q,   wordHi_d;
    logic [15:0] wordCnt_q,  wordCnt_d;
    logic [7:0]  checksum_q, checksum_d;
    logic        romWe_q,    romWe_d;
    logic [14:0] romAddr_q,  romAddr_d;
    logic [15:0] romWdata_q, romWdata_d;

    logic        byteValid;
    logic [7:0]  rxByte;
    logic [15:0] lenRx;
    logic        timerClear;
    logic        timerEnable;
    logic        timerExpired;

    assign byteValid = bus.rx_valid;
    assign rxByte    = bus.rx_data;
    assign lenRx     = {len_q[15:8], rxByte};

    // Any received byte restarts the watchdog; it only runs mid-frame.
    assign timerClear  = byteValid;
    assign timerEnable = isFrameState(state_q);

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uIdleTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerExpired)
    );

    // Next-state and datapath decode; MAGIC only restarts from a resting state.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wordHi_d   = wordHi_q;
        wordCnt_d  = wordCnt_q;
        checksum_d = checksum_q;
        romWe_d    = 1'b0;
        romAddr_d  = romAddr_q;
        romWdata_d = romWdata_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (byteValid && (rxByte == MAGIC)) begin
                    state_d = LEN_HI;
                end
            end

            LEN_HI: begin
                if (byteValid) begin
                    len_d   = {rxByte, 8'h00};
                    state_d = LEN_LO;
                end else if (timerExpired) begin
                    state_d = ERROR;
                end
            end

            LEN_LO: begin
                if (byteValid) begin
                    len_d      = lenRx;
                    wordCnt_d  = '0;
                    checksum_d = '0;
                    if (lenRx > MAX_LEN) begin
                        state_d = ERROR;
                    end else if (lenRx == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end else if (timerExpired) begin
                    state_d = ERROR;
                end
            end

            DATA_HI: begin
                if (byteValid) begin
                    wordHi_d   = rxByte;
                    checksum_d = checksum_q + rxByte;
                    state_d    = DATA_LO;
                end else if (timerExpired) begin
                    state_d = ERROR;
                end
            end

            DATA_LO: begin
                if (byteValid) begin
                    romWe_d    = 1'b1;
                    romAddr_d  = wordCnt_q[14:0];
                    romWdata_d = {wordHi_q, rxByte};
                    checksum_d = checksum_q + rxByte;
                    wordCnt_d  = wordCnt_q + 16'd1;
                    if (wordCnt_q == (len_q - 16'd1)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end else if (timerExpired) begin
                    state_d = ERROR;
                end
            end

            CHECK: begin
                if (byteValid) begin
                    if (rxByte == checksum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                    end
                end else if (timerExpired) begin
                    state_d = ERROR;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wordHi_q   <= '0;
            wordCnt_q  <= '0;
            checksum_q <= '0;
            romWe_q    <= 1'b0;
            romAddr_q  <= '0;
            romWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wordHi_q   <= wordHi_d;
            wordCnt_q  <= wordCnt_d;
            checksum_q <= checksum_d;
            romWe_q    <= romWe_d;
            romAddr_q  <= romAddr_d;
            romWdata_q <= romWdata_d;
        end
    end

    assign bus.rom_we    = romWe_q;
    assign bus.rom_addr  = romAddr_q;
    assign bus.rom_wdata = romWdata_q;

    // Status decodes straight from the state register so leaving DONE
    // re-asserts the CPU reset on the very edge the state changes.
    assign cpu_reset = (state_q != DONE);
    assign busy      = isFrameState(state_q);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: memory writes are checked against a
// scoreboard queue; status outputs are checked inline per scenario.
module tb_rom_loader;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic cpu_reset, busy, done, error;
    int   checks = 0;
    int   errors = 0;
    wr_t  sb[$];

    rom_loader_if bus ();

    rom_loader #(
        .TIMEOUT_CYCLES(100),
        .MAGIC         (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Write monitor: every rom_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t expW;
        if (bus.rom_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, expected no write", bus.rom_addr, bus.rom_wdata);
            end else begin
                expW = sb.pop_front();
                if (bus.rom_addr !== expW.addr || bus.rom_wdata !== expW.data) begin
                    errors++;
                    $display("[TB] FAIL write_value: got addr=%h data=%h, expected addr=%h data=%h", bus.rom_addr, bus.rom_wdata, expW.addr, expW.data);
                end
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pushWrite(input logic [14:0] a, input logic [15:0] d);
        sb.push_back({a, d});
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_reset: got %b, expected 1", cpu_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got done=%b error=%b, expected 0 0", done, error); end
        checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_we: got %b, expected 0", bus.rom_we); end
        checks++; if (bus.rom_addr !== 15'h0 || bus.rom_wdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rom_bus: got addr=%h data=%h, expected 0 0", bus.rom_addr, bus.rom_wdata); end
    endtask

    task automatic test_good_frame();
        sendByte(8'hA5);
        sendByte(8'h00);
        checks++; if (busy !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL good_midframe: got busy=%b cpu_reset=%b, expected 1 1", busy, cpu_reset); end
        sendByte(8'h02);
        sendByte(8'h00);
        pushWrite(15'd0, 16'h0035);
        sendByte(8'h35);
        sendByte(8'hEC);
        pushWrite(15'd1, 16'hEC10);
        sendByte(8'h10);
        sendByte(8'h31);
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL good_done: got %b, expected 1", done); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL good_cpu_reset: got %b, expected 0", cpu_reset); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL good_flags: got busy=%b error=%b, expected 0 0", busy, error); end
        checks++; if (bus.rom_addr !== 15'd1 || bus.rom_wdata !== 16'hEC10) begin errors++; $display("[TB] FAIL good_hold: got addr=%h data=%h, expected 0001 ec10", bus.rom_addr, bus.rom_wdata); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL good_writes_left: got %0d pending, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_done_ignore();
        sendByte(8'h00);
        sendByte(8'hFF);
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL done_ignore: got done=%b cpu_reset=%b, expected 1 0", done, cpu_reset); end
        @(negedge clk);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL done_before_edge: got cpu_reset=%b, expected 0", cpu_reset); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL done_restart: got busy=%b cpu_reset=%b done=%b, expected 1 1 0", busy, cpu_reset, done); end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h00);
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_reload_empty: got %b, expected 1", done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame [8];
        logic [7:0] sum;
        frame[0] = 8'hA5; frame[1] = 8'h00; frame[2] = 8'h02;
        frame[3] = 8'hA5; frame[4] = 8'hA5; frame[5] = 8'h00; frame[6] = 8'hA5;
        sum = 8'h00;
        for (int i = 3; i < 7; i++) sum = sum + frame[i];
        frame[7] = sum;
        pushWrite(15'd0, {frame[3], frame[4]});
        pushWrite(15'd1, {frame[5], frame[6]});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.rx_data  = frame[i];
            bus.rx_valid = 1'b1;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("[TB] FAIL b2b_magic_data: got done=%b error=%b, expected 1 0", done, error); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL b2b_writes_left: got %0d pending, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_bad_checksum();
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        pushWrite(15'd0, 16'h1234);
        sendByte(8'h34);
        sendByte(8'h00);
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL badsum_flags: got error=%b cpu_reset=%b done=%b, expected 1 1 0", error, cpu_reset, done); end
        checks++; if (bus.rom_addr !== 15'd0 || bus.rom_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL badsum_hold: got addr=%h data=%h, expected 0000 1234", bus.rom_addr, bus.rom_wdata); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL badsum_writes_left: got %0d pending, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_bad_length();
        sendByte(8'hA5);
        sendByte(8'h80);
        sendByte(8'h01);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL badlen_error: got error=%b busy=%b, expected 1 0", error, busy); end
        repeat (2) @(negedge clk);
        sendByte(8'hA5);
        sendByte(8'h80);
        sendByte(8'h00);
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("[TB] FAIL maxlen_accept: got busy=%b error=%b, expected 1 0", busy, error); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("[TB] FAIL maxlen_abort: got busy=%b cpu_reset=%b, expected 0 1", busy, cpu_reset); end
    endtask

    task automatic test_zero_length();
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h00);
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("[TB] FAIL zero_len: got done=%b cpu_reset=%b, expected 1 0", done, cpu_reset); end
    endtask

    task automatic test_timeout();
        int waited;
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        repeat (94) @(negedge clk);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early: got error=%b busy=%b, expected 0 1", error, busy); end
        waited = 0;
        while (error !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_fire: got error=%b after %0d extra cycles, expected 1", error, waited); end
        checks++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_status: got cpu_reset=%b busy=%b, expected 1 0", cpu_reset, busy); end
    endtask

    task automatic test_reset_midframe();
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h02);
        sendByte(8'h00);
        pushWrite(15'd0, 16'h0035);
        sendByte(8'h35);
        sendByte(8'hEC);
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_data  = 8'h10;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL midreset_status: got busy=%b cpu_reset=%b done=%b error=%b, expected 0 1 0 0", busy, cpu_reset, done, error); end
        checks++; if (bus.rom_addr !== 15'h0 || bus.rom_wdata !== 16'h0) begin errors++; $display("[TB] FAIL midreset_rom_bus: got addr=%h data=%h, expected 0 0", bus.rom_addr, bus.rom_wdata); end
        sendByte(8'h10);
        sendByte(8'h31);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ignore: got busy=%b done=%b, expected 0 0", busy, done); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL midreset_writes_left: got %0d pending, expected 0", sb.size()); sb.delete(); end
    endtask

    // Scenario sequence; each test starts from the state the previous one left.
    initial begin
        test_reset();
        test_good_frame();
        test_done_ignore();
        test_back_to_back();
        test_bad_checksum();
        test_bad_length();
        test_zero_length();
        test_timeout();
        test_reset_midframe();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 27_000_000, inter-byte timeout in clk cycles (1 s at 27 MHz).
REQ-002 Parameter MAGIC, default 8'hA5, frame start byte.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the byte source (UART receiver).
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid and consumed in that cycle.
REQ-007 rom_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 rom_addr  output  15  instruction-memory word address.
REQ-009 rom_wdata  output  16  instruction word to write.
REQ-010 cpu_reset  output  1  hold the CPU in reset; drives the CPU reset input.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 done  output  1  last frame loaded and checksum matched.
REQ-013 error  output  1  last frame aborted: bad length, bad checksum or timeout.

Function
REQ-014 Frame format SHALL be: MAGIC, LEN_HI, LEN_LO (word count N, 16-bit), then N words, each sent high byte first, then one checksum byte.
REQ-015 Checksum SHALL be the 8-bit modulo-256 sum of all 2N data bytes; header bytes excluded.
REQ-016 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-017 IDLE, DONE, ERROR: rx_valid with rx_data==MAGIC -> LEN_HI; any other byte ignored, state unchanged.
REQ-018 LEN_HI -> LEN_LO on byte, which is latched as N[15:8].
REQ-019 LEN_LO: N[7:0] latched; N>32768 -> ERROR; N==0 -> CHECK; else -> DATA_HI with word address 0 and checksum 0.
REQ-020 DATA_HI: byte latched as word[15:8] -> DATA_LO.
REQ-021 DATA_LO: on byte, rom_we SHALL pulse high in the next cycle with rom_wdata={hi,lo} and rom_addr = current word index; last word -> CHECK, else -> DATA_HI.
REQ-022 Word index SHALL start at 0, increment after each write and never wrap; 32768 words end at address 15'h7FFF.
REQ-023 CHECK: byte equal to the running checksum -> DONE, else -> ERROR.
REQ-024 Timeout counter SHALL clear on every accepted byte and on entering LEN_HI; in LEN_HI..CHECK, reaching TIMEOUT_CYCLES with no byte -> ERROR.
REQ-025 cpu_reset SHALL be 1 in every state except DONE; DONE -> LEN_HI re-asserts cpu_reset in the same cycle as the state change.
REQ-026 busy SHALL be 1 in LEN_HI..CHECK; done==1 only in DONE; error==1 only in ERROR.
REQ-027 rom_we SHALL be 0 at all times except REQ-021 pulses; rom_addr/rom_wdata hold their last values between pulses.
REQ-028 Words written before a checksum or timeout failure stay in memory; no rollback; CPU stays held.
REQ-029 MAGIC bytes inside LEN/DATA/CHECK SHALL be treated as data, not as a restart.

Reset
REQ-030 reset SHALL force state IDLE, cpu_reset=1, rom_we=0, rom_addr=0, rom_wdata=0, busy=0, done=0, error=0, checksum=0, timeout counter=0.
REQ-031 reset mid-frame SHALL abandon the frame; rx_valid in the reset cycle SHALL be ignored.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum typedef, the MAGIC default and the maximum word count 32768.
REQ-033 The timeout counter SHALL be one sub-module, idle_timer (clear, enable, expired), parameterised by TIMEOUT_CYCLES.
REQ-034 rom_loader SHALL sit between the UART receiver and the instruction memory write port of computer; the CPU reads only ports that rom_loader does not drive.

Verification (TIMEOUT_CYCLES=100 in the bench)
REQ-035 A5 00 02 00 35 EC 10 31 -> writes addr0=16'h0035, addr1=16'hEC10; done=1, cpu_reset=0.
REQ-036 A5 00 01 12 34 00 -> one write, addr0=16'h1234; then error=1, cpu_reset=1.
REQ-037 A5 80 01 -> error immediately after LEN_LO, no rom_we pulse.
REQ-038 A5 00 00 00 -> done=1, no writes; A5 00 01 12, then 100 idle cycles -> error=1.
REQ-039 reset asserted after A5 00 02 00 35 EC -> IDLE, cpu_reset=1, later 10 31 ignored, no further writes.
REQ-040 While done, bytes 00 FF -> stay DONE; then A5 -> busy=1, cpu_reset=1 in the same cycle as the state change.
